// File: rtl/umul_seq_ctrl_pkg.sv
// Shared definitions for the unary-multiplier sequencer.
// Package umul_ctrl_pkg: FSM state enum, default sizing, and sizing helpers.
package umul_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        CLR  = 3'd3,
        DONE = 3'd4
    } umul_state_e;

    localparam int DEF_BITWIDTH = 8;
    localparam int DEF_MULT_LAT = 1;
    localparam int MAX_MULT_LAT = 3;

    // Run length and accumulator width for the default operand width.
    localparam int RUN_LEN = 1 << DEF_BITWIDTH;
    localparam int ACC_W   = DEF_BITWIDTH + 1;

    // Unary run length for a given operand width.
    function automatic int runLen(input int bitwidth);
        return 1 << bitwidth;
    endfunction

    // Ones-count width: one extra bit holds the full-run count 2^bitwidth.
    function automatic int accWidth(input int bitwidth);
        return bitwidth + 1;
    endfunction

    // Cycle counter width: must reach 2^bitwidth + MAX_MULT_LAT - 1.
    function automatic int cntWidth(input int bitwidth);
        return bitwidth + 2;
    endfunction

    // Multiplier latencies the sequencer is built to absorb.
    function automatic bit multLatOk(input int lat);
        return (lat >= 0) && (lat <= MAX_MULT_LAT);
    endfunction

endpackage

// File: rtl/umul_seq_ctrl_if.sv
// Request/result handshake bundle between a binary front end and umul_seq_ctrl.
// Signal names are given from the controller's point of view.
interface umul_seq_ctrl_if
    import umul_ctrl_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) ();

    // Request channel
    logic                iValid;
    logic                oReady;
    logic [BITWIDTH-1:0] iA;
    logic [BITWIDTH-1:0] iB;

    // Result channel
    logic                oValid;
    logic                iReady;
    logic [BITWIDTH:0]   oResult;

    // Controller side
    modport slave (
        input  iValid, iA, iB, iReady,
        output oReady, oValid, oResult
    );

    // Requester side
    modport master (
        output iValid, iA, iB, iReady,
        input  oReady, oValid, oResult
    );

endinterface

// File: rtl/umul_unary_gen.sv
// Unary stream generator: cycle counter plus comparator.
// Produces the thermometer-coded A bitstream (exactly A ones, then zeros),
// the accumulate window that lines up with the multiplier latency, and the
// last-cycle flag that ends the run.
module umul_unary_gen
    import umul_ctrl_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic                iRun,
    input  logic [BITWIDTH-1:0] iA,
    output logic                oBit,
    output logic                oAccEn,
    output logic                oLast
);

    localparam int               CNT_W  = cntWidth(BITWIDTH);
    localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(runLen(BITWIDTH) + MULT_LAT);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(runLen(BITWIDTH) + MULT_LAT - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntInc;
    logic [CNT_W-1:0] aExt;

    assign cntInc = cnt + CNT_W'(1);
    assign aExt   = CNT_W'(iA);

    // Ones from the multiplier are counted only once its pipeline has filled.
    assign oAccEn = iRun && (cnt >= WIN_LO) && (cnt < WIN_HI);
    assign oLast  = iRun && (cnt == LAST);

    // Counter and registered stream bit; the bit for cycle c is prepared from c's count.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt  <= '0;
            oBit <= 1'b0;
        end else if (iStart) begin
            cnt  <= '0;
            oBit <= (aExt != '0);
        end else if (iRun && !oLast) begin
            cnt  <= cntInc;
            // cntInc < A implies cntInc < 2^BITWIDTH, so the tail stays zero.
            oBit <= (cntInc < aExt);
        end else begin
            cnt  <= '0;
            oBit <= 1'b0;
        end
    end

endmodule

// File: rtl/umul_seq_ctrl.sv
// Sequencer for one rep_uMUL unary multiplier.
// Accepts an operand pair, loads B into the multiplier, streams A as a
// thermometer code for 2^BITWIDTH cycles, counts the multiplier's ones,
// clears the multiplier and returns the count as the product.
// Optional build macro: UMUL_SEQ_ZERO_SKIP_EN -- a zero operand skips
// LOAD/RUN and returns 0 straight from CLR/DONE.
module umul_seq_ctrl
    import umul_ctrl_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic                iClk,
    input  logic                iRst,
    umul_seq_ctrl_if.slave      bus,
    output logic                oA,
    output logic [BITWIDTH-1:0] oB,
    output logic                oLoadB,
    output logic                oClr,
    input  logic                iMult
);

    localparam int ACC_WIDTH = accWidth(BITWIDTH);

    generate
        if (!multLatOk(MULT_LAT)) begin : gMultLatRange
            $error("umul_seq_ctrl: MULT_LAT must be within 0..3");
        end
    endgenerate

    umul_state_e            state;
    umul_state_e            nextState;
    logic [BITWIDTH-1:0]    aReg;
    logic [BITWIDTH-1:0]    bReg;
    logic [ACC_WIDTH-1:0]   acc;
    logic                   readyReg;
    logic                   validReg;
    logic                   loadReg;
    logic                   clrReg;
    logic                   accept;
    logic                   zeroOp;
    logic                   genBit;
    logic                   accEn;
    logic                   runLast;

    assign accept = bus.iValid && readyReg && (state == IDLE);

`ifdef UMUL_SEQ_ZERO_SKIP_EN
    assign zeroOp = (bus.iA == '0) || (bus.iB == '0);
`else
    assign zeroOp = 1'b0;
`endif

    umul_unary_gen #(
        .BITWIDTH (BITWIDTH),
        .MULT_LAT (MULT_LAT)
    ) uGen (
        .iClk   (iClk),
        .iRst   (iRst),
        .iStart (state == LOAD),
        .iRun   (state == RUN),
        .iA     (aReg),
        .oBit   (genBit),
        .oAccEn (accEn),
        .oLast  (runLast)
    );

    // State register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state logic.
    // NOTE: nextState is defaulted before the case so no path leaves it unassigned.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = zeroOp ? CLR : LOAD;
            LOAD:    nextState = RUN;
            RUN:     if (runLast) nextState = CLR;
            CLR:     nextState = DONE;
            DONE:    if (validReg && bus.iReady) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Operand capture on an accepted request; B stays on oB until the next request.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            aReg <= '0;
            bReg <= '0;
        end else if (accept) begin
            aReg <= bus.iA;
            bReg <= bus.iB;
        end
    end

    // Ones counter; cleared while idle/loading, counts inside the latency-aligned window.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            acc <= '0;
        end else if (state == IDLE || state == LOAD) begin
            acc <= '0;
        end else if (accEn && iMult) begin
            acc <= acc + ACC_WIDTH'(1);
        end
    end

    // Registered handshake and strobe outputs decoded from the upcoming state.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            readyReg <= 1'b0;
            validReg <= 1'b0;
            loadReg  <= 1'b0;
            clrReg   <= 1'b0;
        end else begin
            readyReg <= (nextState == IDLE);
            validReg <= (nextState == DONE);
            loadReg  <= (nextState == LOAD);
            clrReg   <= (nextState == CLR);
        end
    end

    assign bus.oReady  = readyReg;
    assign bus.oValid  = validReg;
    assign bus.oResult = acc;
    assign oA          = genBit;
    assign oB          = bReg;
    assign oLoadB      = loadReg;
    assign oClr        = clrReg;

endmodule

// File: tb/tb_umul_seq_ctrl.sv
// Directed bench for umul_seq_ctrl (BITWIDTH=8, MULT_LAT=1).
// iMult comes from a selectable source: oA looped back through one flop,
// stuck at 1, stuck at 0, or a small rep_uMUL behavioural model.
module tb_umul_seq_ctrl;
    import umul_ctrl_pkg::*;

    localparam int BW = 8;
    // Accept edge -> oValid: LOAD 1 + RUN 257 + CLR 1 = 259 edges (cycle k+260).
    localparam int FULL_EDGES = 259;
    localparam int WAIT_LIMIT = 400;

    localparam logic [1:0] M_LOOP = 2'd0;
    localparam logic [1:0] M_ONE  = 2'd1;
    localparam logic [1:0] M_ZERO = 2'd2;
    localparam logic [1:0] M_UMUL = 2'd3;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          oA;
    logic [BW-1:0] oB;
    logic          oLoadB;
    logic          oClr;
    logic          iMult;
    logic [1:0]    mode = M_LOOP;
    logic          loopQ = 1'b0;
    logic [BW-1:0] mulB = '0;
    logic [BW-1:0] mulIdx = '0;
    logic          mulOut = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int edges = 0;
    int loadCnt = 0;
    int clrCnt = 0;

    umul_seq_ctrl_if #(.BITWIDTH(BW)) bus ();

    umul_seq_ctrl #(
        .BITWIDTH (BW),
        .MULT_LAT (1)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .bus    (bus),
        .oA     (oA),
        .oB     (oB),
        .oLoadB (oLoadB),
        .oClr   (oClr),
        .iMult  (iMult)
    );

    always #5 iClk = ~iClk;

    function automatic logic [BW-1:0] bitRev(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        for (int i = 0; i < BW; i++) r[i] = v[BW-1-i];
        return r;
    endfunction

    // One-cycle loopback path matching MULT_LAT=1.
    always @(posedge iClk) loopQ <= oA;

    // rep_uMUL model: van der Corput RNG advances on A=1, registered output.
    always @(posedge iClk or posedge iRst) begin
        if (iRst || oClr) begin
            mulIdx <= '0;
            mulOut <= 1'b0;
        end else begin
            if (oLoadB) mulB <= oB;
            mulOut <= oA & (mulB > bitRev(mulIdx));
            if (oA) mulIdx <= mulIdx + 8'd1;
        end
    end

    always_comb begin
        iMult = 1'b0;
        case (mode)
            M_LOOP:  iMult = loopQ;
            M_ONE:   iMult = 1'b1;
            M_ZERO:  iMult = 1'b0;
            default: iMult = mulOut;
        endcase
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Present a request and return just after the accepting edge.
    task automatic issue(input logic [BW-1:0] a, input logic [BW-1:0] b);
        int waitCnt = 0;
        while (bus.oReady !== 1'b1 && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        vectors++;
        if (bus.oReady !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready: oReady=%b want 1", bus.oReady);
        end
        bus.iValid = 1'b1;
        bus.iA = a;
        bus.iB = b;
        tick();
        bus.iValid = 1'b0;
    endtask

    // Count edges after acceptance until oValid, tallying strobe cycles on the way.
    task automatic waitResult();
        edges = 0;
        loadCnt = 0;
        clrCnt = 0;
        while (bus.oValid !== 1'b1 && edges < WAIT_LIMIT) begin
            if (oLoadB === 1'b1) loadCnt++;
            if (oClr === 1'b1) clrCnt++;
            tick();
            edges++;
        end
    endtask

    task automatic respond();
        bus.iReady = 1'b1;
        tick();
        bus.iReady = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) begin
            tick();
            vectors++;
            if ({bus.oReady, bus.oValid, oA, oLoadB, oClr} !== 5'b0 ||
                oB !== 8'd0 || bus.oResult !== 9'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: rdy=%b vld=%b a=%b ld=%b clr=%b b=%0d res=%0d want all 0",
                         bus.oReady, bus.oValid, oA, oLoadB, oClr, oB, bus.oResult);
            end
        end
        iRst = 1'b0;
        tick();
        vectors++;
        if (bus.oReady !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready: oReady=%b want 1", bus.oReady);
        end
        vectors++;
        if (bus.oValid !== 1'b0) begin
            miscompares++;
            $display("FAIL release_valid: oValid=%b want 0", bus.oValid);
        end
    endtask

    task automatic test_loopback();
        mode = M_LOOP;
        issue(8'd157, 8'd33);
        waitResult();
        vectors++;
        if (edges != FULL_EDGES) begin
            miscompares++;
            $display("FAIL loop_latency: edges=%0d want %0d", edges, FULL_EDGES);
        end
        vectors++;
        if (bus.oResult !== 9'd157) begin
            miscompares++;
            $display("FAIL loop_result: got %0d want 157", bus.oResult);
        end
        vectors++;
        if (loadCnt != 1 || clrCnt != 1) begin
            miscompares++;
            $display("FAIL loop_strobes: loadB=%0d clr=%0d cycles want 1 and 1", loadCnt, clrCnt);
        end
        vectors++;
        if (oB !== 8'd33) begin
            miscompares++;
            $display("FAIL loop_oB: got %0d want 33", oB);
        end
        respond();
        vectors++;
        if (bus.oReady !== 1'b1 || bus.oValid !== 1'b0) begin
            miscompares++;
            $display("FAIL loop_return_idle: rdy=%b vld=%b want 1/0", bus.oReady, bus.oValid);
        end
    endtask

    task automatic test_stuck();
        mode = M_ONE;
        issue(8'd255, 8'd5);
        waitResult();
        vectors++;
        if (bus.oResult !== 9'd256) begin
            miscompares++;
            $display("FAIL stuck_one_result: got %0d want 256", bus.oResult);
        end
        respond();
        mode = M_ZERO;
        issue(8'd200, 8'd1);
        waitResult();
        vectors++;
        if (bus.oResult !== 9'd0 || edges != FULL_EDGES) begin
            miscompares++;
            $display("FAIL stuck_zero: result=%0d edges=%0d want 0 and %0d", bus.oResult, edges, FULL_EDGES);
        end
        respond();
        // A=0 with loopback: an all-zero thermometer stream.
        mode = M_LOOP;
        issue(8'd0, 8'd9);
        waitResult();
        vectors++;
        if (bus.oResult !== 9'd0) begin
            miscompares++;
            $display("FAIL zero_a_result: got %0d want 0", bus.oResult);
        end
`ifndef UMUL_SEQ_ZERO_SKIP_EN
        vectors++;
        if (edges != FULL_EDGES || loadCnt != 1) begin
            miscompares++;
            $display("FAIL zero_a_full_run: edges=%0d loadB=%0d want %0d and 1", edges, loadCnt, FULL_EDGES);
        end
`endif
        respond();
    endtask

    task automatic test_real_umul();
        mode = M_UMUL;
        // Even reversals 0..254 below 157: 79 ones, inside 78 +/- 2.
        issue(8'd128, 8'd157);
        waitResult();
        vectors++;
        if (bus.oResult < 9'd76 || bus.oResult > 9'd80) begin
            miscompares++;
            $display("FAIL umul_128x157: got %0d want 76..80", bus.oResult);
        end
        respond();
        issue(8'd255, 8'd0);
        waitResult();
        vectors++;
        if (bus.oResult !== 9'd0) begin
            miscompares++;
            $display("FAIL umul_255x0: got %0d want 0", bus.oResult);
        end
        respond();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        mode = M_LOOP;
        issue(8'd20, 8'd3);
        waitResult();
        vectors++;
        if (bus.oResult !== 9'd20) begin
            miscompares++;
            $display("FAIL bp_result: got %0d want 20", bus.oResult);
        end
        bus.iValid = 1'b1;
        bus.iA = 8'd99;
        bus.iB = 8'd99;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.oValid !== 1'b1 || bus.oResult !== 9'd20 || bus.oReady !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
        end
        bus.iValid = 1'b0;
        respond();
        vectors++;
        if (bus.oReady !== 1'b1 || bus.oValid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: rdy=%b vld=%b want 1/0", bus.oReady, bus.oValid);
        end
        vectors++;
        if (oB !== 8'd3) begin
            miscompares++;
            $display("FAIL bp_ignored_req: oB=%0d want 3", oB);
        end
    endtask

    task automatic test_reset_mid_run();
        int vldSeen = 0;
        int clrSeen = 0;
        mode = M_LOOP;
        issue(8'd200, 8'd7);
        repeat (101) tick();
        vectors++;
        if (oA !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_stream: oA=%b want 1 at RUN cycle 100", oA);
        end
        iRst = 1'b1;
        #1;
        vectors++;
        if ({bus.oReady, bus.oValid, oA, oLoadB, oClr} !== 5'b0 || oB !== 8'd0 || bus.oResult !== 9'd0) begin
            miscompares++;
            $display("FAIL midrun_async_reset: rdy=%b vld=%b a=%b b=%0d res=%0d want all 0",
                     bus.oReady, bus.oValid, oA, oB, bus.oResult);
        end
        tick();
        tick();
        iRst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.oValid === 1'b1) vldSeen++;
            if (oClr === 1'b1) clrSeen++;
        end
        vectors++;
        if (vldSeen != 0 || clrSeen != 0) begin
            miscompares++;
            $display("FAIL midrun_discard: oValid=%0d oClr=%0d cycles want 0 and 0", vldSeen, clrSeen);
        end
        issue(8'd10, 8'd4);
        waitResult();
        vectors++;
        if (bus.oResult !== 9'd10) begin
            miscompares++;
            $display("FAIL midrun_fresh: got %0d want 10", bus.oResult);
        end
        respond();
    endtask

`ifdef UMUL_SEQ_ZERO_SKIP_EN
    task automatic test_zero_skip();
        mode = M_ONE;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) issue(8'd77, 8'd0);
            else        issue(8'd0, 8'd9);
            waitResult();
            // Accept -> CLR -> DONE: oValid in cycle k+2, one edge after acceptance.
            vectors++;
            if (edges != 1) begin
                miscompares++;
                $display("FAIL skip_latency[%0d]: edges=%0d want 1", i, edges);
            end
            vectors++;
            if (bus.oResult !== 9'd0) begin
                miscompares++;
                $display("FAIL skip_result[%0d]: got %0d want 0", i, bus.oResult);
            end
            vectors++;
            if (loadCnt != 0) begin
                miscompares++;
                $display("FAIL skip_no_loadb[%0d]: loadB cycles=%0d want 0", i, loadCnt);
            end
            respond();
        end
    endtask
`endif

    initial begin
        bus.iValid = 1'b0;
        bus.iA = '0;
        bus.iB = '0;
        bus.iReady = 1'b0;
        test_reset();
        test_loopback();
        test_stuck();
        test_real_umul();
        test_backpressure();
        test_reset_mid_run();
`ifdef UMUL_SEQ_ZERO_SKIP_EN
        test_zero_skip();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
